// File: rtl/gpu_op_queue_pkg.sv
// Shared class-bit offsets, operation types and the class decoder for the
// multi-channel GPU op queue.
package gpu_op_queue_pkg;

    localparam int CLS_VEC = 0;
    localparam int CLS_WR  = 1;
    localparam int CLS_RD  = 2;

    localparam int OP_INSTR_W = 80;
    localparam int OP_ADDR_W  = 32;

    typedef enum logic [1:0] {
        SCALAR = 2'd0,
        VECTOR = 2'd1,
        READ   = 2'd2,
        WRITE  = 2'd3
    } op_class_e;

    typedef struct packed {
        logic [OP_INSTR_W-1:0] instr;
        logic [OP_ADDR_W-1:0]  src;
        logic [OP_ADDR_W-1:0]  dst;
    } op_entry_t;

    // Memory writes outrank reads, reads outrank vector ops.
    function automatic op_class_e classify(input logic [2:0] cls);
        if (cls[CLS_WR])       return WRITE;
        else if (cls[CLS_RD])  return READ;
        else if (cls[CLS_VEC]) return VECTOR;
        return SCALAR;
    endfunction

endpackage

// File: rtl/gpu_op_fifo_ch.sv
// Single-channel FIFO: registered occupancy, no fall-through, synchronous flush.
module gpu_op_fifo_ch #(
    parameter  int WIDTH        = 144,
    parameter  int DEPTH        = 16,
    parameter  int NEAR_FULL_TH = 4,
    localparam int CNT_W        = $clog2(DEPTH + 1),
    localparam int PTR_W        = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             nearly_full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= wdata;
    end

    assign rdata       = mem[rd_ptr];
    assign full        = (count == CNT_W'(DEPTH));
    assign empty       = (count == '0);
    assign nearly_full = (DEPTH - int'(count)) <= NEAR_FULL_TH;

endmodule

// File: rtl/gpu_op_queue_mc.sv
// Multi-channel GPU op queue: classifies ops into priority FIFOs and presents
// them with strict priority, anti-starvation aging and a hold-until-accept lock.
module gpu_op_queue_mc import gpu_op_queue_pkg::*; #(
    parameter  int NUM_CH       = 4,
    parameter  int DEPTH        = 16,
    parameter  int INSTR_WIDTH  = 80,
    parameter  int ADDR_WIDTH   = 32,
    parameter  int NEAR_FULL_TH = 4,
    parameter  int STARVE_LIMIT = 8,
    localparam int CH_W         = $clog2(NUM_CH),
    localparam int CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_enq_valid,
    output logic                    o_enq_ready,
    input  logic [INSTR_WIDTH-1:0]  i_instruction,
    input  logic [ADDR_WIDTH-1:0]   i_src_addr,
    input  logic [ADDR_WIDTH-1:0]   i_dst_addr,
    input  logic                    i_ch_ovr_en,
    input  logic [CH_W-1:0]         i_ch_ovr,
    output logic                    o_deq_valid,
    input  logic                    i_deq_ready,
    output logic [INSTR_WIDTH-1:0]  o_instruction,
    output logic [ADDR_WIDTH-1:0]   o_src_addr,
    output logic [ADDR_WIDTH-1:0]   o_dst_addr,
    output logic [CH_W-1:0]         o_deq_ch,
    output logic [NUM_CH*CNT_W-1:0] o_ch_count,
    output logic [NUM_CH-1:0]       o_ch_full,
    output logic [NUM_CH-1:0]       o_nearly_full,
    output logic [NUM_CH-1:0]       o_overflow,
    input  logic                    i_clr_err,
    input  logic                    i_flush
);

    localparam int WAIT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    typedef struct packed {
        logic [INSTR_WIDTH-1:0] instr;
        logic [ADDR_WIDTH-1:0]  src;
        logic [ADDR_WIDTH-1:0]  dst;
    } entry_t;

    entry_t                           enq_ent;
    entry_t [NUM_CH-1:0]              head;
    logic   [NUM_CH-1:0][CNT_W-1:0]   cnt;
    logic   [NUM_CH-1:0][WAIT_W-1:0]  wait_cnt;
    logic   [NUM_CH-1:0]              empty, push, pop, aged, ovf_set;
    logic   [CH_W-1:0]                tgt, arb_ch, lock_ch, deq_ch;
    logic                             lock_vld, any_ne, any_aged, enq_fire, deq_fire;

    function automatic logic [CH_W-1:0] clamp_ch(input int unsigned v);
        return (v >= NUM_CH) ? CH_W'(NUM_CH - 1) : CH_W'(v);
    endfunction

    assign tgt = i_ch_ovr_en ? clamp_ch(32'(i_ch_ovr))
                             : clamp_ch(32'(classify(i_instruction[2:0])));

    assign enq_ent     = '{instr: i_instruction, src: i_src_addr, dst: i_dst_addr};
    assign o_enq_ready = !o_ch_full[tgt];
    assign enq_fire    = i_enq_valid && o_enq_ready && !i_flush;

    // Ascending scan: later (higher) indices overwrite, aged channels lock out non-aged.
    always_comb begin
        arb_ch   = '0;
        any_ne   = 1'b0;
        any_aged = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (aged[c]) begin
                arb_ch   = CH_W'(c);
                any_aged = 1'b1;
            end else if (!empty[c] && !any_aged) begin
                arb_ch = CH_W'(c);
            end
            any_ne = any_ne | !empty[c];
        end
    end

    assign deq_ch      = lock_vld ? lock_ch : arb_ch;
    assign o_deq_valid = any_ne;
    assign o_deq_ch    = deq_ch;
    assign deq_fire    = any_ne && i_deq_ready && !i_flush;

    assign o_instruction = any_ne ? head[deq_ch].instr : '0;
    assign o_src_addr    = any_ne ? head[deq_ch].src   : '0;
    assign o_dst_addr    = any_ne ? head[deq_ch].dst   : '0;
    assign o_ch_count    = cnt;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign push[c]    = enq_fire && (tgt == CH_W'(c));
        assign pop[c]     = deq_fire && (deq_ch == CH_W'(c));
        assign ovf_set[c] = i_enq_valid && !o_enq_ready && !i_flush && (tgt == CH_W'(c));
        assign aged[c]    = (STARVE_LIMIT != 0) && !empty[c] &&
                            (wait_cnt[c] == WAIT_W'(STARVE_LIMIT));

        gpu_op_fifo_ch #(
            .WIDTH        ($bits(entry_t)),
            .DEPTH        (DEPTH),
            .NEAR_FULL_TH (NEAR_FULL_TH)
        ) u_fifo (
            .clk         (clk),
            .rst_n       (rst_n),
            .flush       (i_flush),
            .push        (push[c]),
            .pop         (pop[c]),
            .wdata       (enq_ent),
            .rdata       (head[c]),
            .count       (cnt[c]),
            .full        (o_ch_full[c]),
            .empty       (empty[c]),
            .nearly_full (o_nearly_full[c])
        );
    end

    // A presented-but-unaccepted entry stays put until the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_vld <= 1'b0;
            lock_ch  <= '0;
        end else if (i_flush) begin
            lock_vld <= 1'b0;
            lock_ch  <= '0;
        end else begin
            lock_vld <= any_ne && !i_deq_ready;
            lock_ch  <= deq_ch;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (i_flush || empty[c] || pop[c])
                    wait_cnt[c] <= '0;
                else if (deq_fire && wait_cnt[c] != WAIT_W'(STARVE_LIMIT))
                    wait_cnt[c] <= wait_cnt[c] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) o_overflow <= '0;
        else        o_overflow <= (o_overflow & ~{NUM_CH{i_clr_err}}) | ovf_set;
    end

endmodule

// File: tb/tb_gpu_op_queue_mc.sv
// Bench for gpu_op_queue_mc: directed scenarios then random traffic, all checked
// every cycle against a queue-based reference model.
module tb_gpu_op_queue_mc;

    localparam int NUM_CH = 4, DEPTH = 16, IW = 80, AW = 32, NFT = 4, SL = 8;
    localparam int CH_W = 2, CNT_W = 5, EW = IW + 2 * AW;

    logic clk = 1'b0, rst_n = 1'b0;
    logic enq_valid = 0, ovr_en = 0, deq_ready = 0, flush = 0, clr_err = 0;
    logic [IW-1:0] instr = '0;
    logic [AW-1:0] src = '0, dst = '0;
    logic [CH_W-1:0] ch_ovr = '0;

    logic enq_ready, deq_valid;
    logic [IW-1:0] out_instr;
    logic [AW-1:0] out_src, out_dst;
    logic [CH_W-1:0] deq_ch;
    logic [NUM_CH*CNT_W-1:0] ch_count;
    logic [NUM_CH-1:0] ch_full, nearly_full, overflow;

    always #5 clk = ~clk;

    gpu_op_queue_mc #(
        .NUM_CH(NUM_CH), .DEPTH(DEPTH), .INSTR_WIDTH(IW), .ADDR_WIDTH(AW),
        .NEAR_FULL_TH(NFT), .STARVE_LIMIT(SL)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_enq_valid(enq_valid), .o_enq_ready(enq_ready),
        .i_instruction(instr), .i_src_addr(src), .i_dst_addr(dst),
        .i_ch_ovr_en(ovr_en), .i_ch_ovr(ch_ovr),
        .o_deq_valid(deq_valid), .i_deq_ready(deq_ready),
        .o_instruction(out_instr), .o_src_addr(out_src), .o_dst_addr(out_dst),
        .o_deq_ch(deq_ch), .o_ch_count(ch_count), .o_ch_full(ch_full),
        .o_nearly_full(nearly_full), .o_overflow(overflow),
        .i_clr_err(clr_err), .i_flush(flush)
    );

    int n_chk = 0, n_fail = 0;

    // Reference model: one queue per channel, wait counts, lock, sticky flags.
    logic [EW-1:0] q [NUM_CH][$];
    int wt [NUM_CH];
    bit m_lock;
    int m_lock_ch;
    logic [NUM_CH-1:0] m_ovf;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int m_tgt();
        int t;
        if (ovr_en)        t = int'(ch_ovr);
        else if (instr[1]) t = 3;
        else if (instr[2]) t = 2;
        else if (instr[0]) t = 1;
        else               t = 0;
        return (t > NUM_CH - 1) ? NUM_CH - 1 : t;
    endfunction

    function automatic bit m_valid();
        for (int c = 0; c < NUM_CH; c++) if (q[c].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_ch();
        if (m_lock) return m_lock_ch;
        for (int c = NUM_CH - 1; c >= 0; c--)
            if (q[c].size() > 0 && SL != 0 && wt[c] == SL) return c;
        for (int c = NUM_CH - 1; c >= 0; c--)
            if (q[c].size() > 0) return c;
        return 0;
    endfunction

    task automatic check_all();
        int ch;
        logic [EW-1:0] hd;
        logic [NUM_CH*CNT_W-1:0] cnts;
        logic [NUM_CH-1:0] fl, nf;
        ch = m_ch();
        hd = m_valid() ? q[ch][0] : '0;
        for (int c = 0; c < NUM_CH; c++) begin
            cnts[c*CNT_W +: CNT_W] = CNT_W'(q[c].size());
            fl[c] = (q[c].size() == DEPTH);
            nf[c] = (DEPTH - q[c].size()) <= NFT;
        end
        chk("deq_valid", deq_valid, m_valid());
        chk("deq_ch", deq_ch, ch);
        chk("instr", out_instr, hd[EW-1:2*AW]);
        chk("src", out_src, hd[2*AW-1:AW]);
        chk("dst", out_dst, hd[AW-1:0]);
        chk("enq_ready", enq_ready, !fl[m_tgt()]);
        chk("ch_count", ch_count, cnts);
        chk("ch_full", ch_full, fl);
        chk("nearly_full", nearly_full, nf);
        chk("overflow", overflow, m_ovf);
    endtask

    task automatic m_step();
        bit v, dq, rdy_t;
        int ch, t;
        v = m_valid();
        ch = m_ch();
        t = m_tgt();
        rdy_t = q[t].size() < DEPTH;
        if (clr_err) m_ovf = '0;
        if (flush) begin
            for (int c = 0; c < NUM_CH; c++) begin
                q[c].delete();
                wt[c] = 0;
            end
            m_lock = 0;
        end else begin
            if (enq_valid && !rdy_t) m_ovf[t] = 1'b1;
            dq = v && deq_ready;
            for (int c = 0; c < NUM_CH; c++) begin
                if (q[c].size() == 0)    wt[c] = 0;
                else if (dq && c == ch)  wt[c] = 0;
                else if (dq && wt[c] < SL) wt[c]++;
            end
            m_lock = v && !deq_ready;
            m_lock_ch = ch;
            if (dq) void'(q[ch].pop_front());
            if (enq_valid && rdy_t) q[t].push_back({instr, src, dst});
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        check_all();
        @(posedge clk);
        m_step();
        #1;
    endtask

    task automatic idle();
        enq_valid = 0; flush = 0; clr_err = 0; ovr_en = 0;
    endtask

    task automatic set_op(input logic [2:0] cls);
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        instr = r[IW-1:0];
        instr[2:0] = cls;
        src = $urandom();
        dst = $urandom();
    endtask

    task automatic enq(input logic [2:0] cls);
        idle();
        enq_valid = 1;
        set_op(cls);
    endtask

    logic [IW-1:0] v_instr;
    int gn;
    logic [NUM_CH*CNT_W-1:0] exp_cnt;

    initial begin
        m_lock = 0; m_lock_ch = 0; m_ovf = '0;
        for (int c = 0; c < NUM_CH; c++) wt[c] = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;

        // reset state
        chk("rst_valid", deq_valid, 0);
        chk("rst_enq_ready", enq_ready, 1);
        chk("rst_count", ch_count, 0);
        cyc();

        // single scalar op, visible one cycle after the write
        deq_ready = 0; enq(3'b000); cyc();
        chk("t1_valid", deq_valid, 1);
        chk("t1_ch", deq_ch, 0);
        chk("t1_cnt0", ch_count[CNT_W-1:0], 1);
        idle(); deq_ready = 1; cyc();
        chk("t1_drained", deq_valid, 0);

        // lock on ch1, later arrivals queue behind it, then priority order
        deq_ready = 0; enq(3'b001); v_instr = instr; cyc();
        enq(3'b000); cyc();
        enq(3'b010); cyc();
        idle(); cyc();
        chk("t2_lock_ch", deq_ch, 1);
        chk("t2_lock_instr", out_instr, v_instr);
        deq_ready = 1; cyc();
        chk("t2_second", deq_ch, 3);
        cyc();
        chk("t2_third", deq_ch, 0);
        cyc();
        chk("t2_empty", deq_valid, 0);

        // fill ch2, overflow, clear semantics
        deq_ready = 0;
        for (int i = 0; i < DEPTH; i++) begin enq(3'b100); cyc(); end
        chk("t3_full_cnt", ch_count[2*CNT_W +: CNT_W], DEPTH);
        chk("t3_full", ch_full, 4'b0100);
        enq(3'b100); cyc();
        chk("t3_ovf", overflow, 4'b0100);
        chk("t3_cnt_kept", ch_count[2*CNT_W +: CNT_W], DEPTH);
        enq(3'b100); clr_err = 1; cyc();
        chk("t3_set_wins", overflow, 4'b0100);
        idle(); clr_err = 1; cyc();
        chk("t3_cleared", overflow, 4'b0000);
        enq(3'b100); deq_ready = 1; cyc();
        chk("t3_full_pop_rej", overflow, 4'b0100);
        chk("t3_cnt_15", ch_count[2*CNT_W +: CNT_W], DEPTH - 1);
        idle();
        for (int i = 0; i < DEPTH - 1; i++) cyc();
        chk("t3_drained", deq_valid, 0);

        // aging: ch0 starved behind a permanently busy ch3
        deq_ready = 0;
        for (int i = 0; i < 10; i++) begin enq(3'b010); cyc(); end
        enq(3'b000); cyc();
        deq_ready = 1;
        gn = -1;
        for (int i = 1; i <= 30; i++) begin
            if (deq_valid && deq_ch == 0) begin gn = i; break; end
            enq(3'b010); cyc();
        end
        chk("t4_aged_grant_no", gn, 9);
        idle();
        for (int i = 0; i < 20; i++) cyc();
        chk("t4_drained", deq_valid, 0);

        // flush with a simultaneous enqueue and dequeue
        deq_ready = 0;
        for (int i = 0; i < 3; i++) begin enq(3'b000); cyc(); end
        for (int i = 0; i < 2; i++) begin enq(3'b001); cyc(); end
        for (int i = 0; i < 5; i++) begin enq(3'b010); cyc(); end
        exp_cnt = {5'd5, 5'd0, 5'd2, 5'd3};
        chk("t5_pre_counts", ch_count, exp_cnt);
        enq(3'b010); flush = 1; deq_ready = 1; cyc();
        chk("t5_counts", ch_count, 0);
        chk("t5_valid", deq_valid, 0);
        chk("t5_ovf_kept", overflow, 4'b0100);
        idle(); clr_err = 1; cyc();
        chk("t5_clr", overflow, 0);

        // random traffic: draining phase then filling phase
        for (int i = 0; i < 1600; i++) begin
            enq_valid = ($urandom_range(9) < 7);
            set_op(3'($urandom_range(7)));
            ovr_en = ($urandom_range(3) == 0);
            ch_ovr = CH_W'($urandom_range(NUM_CH - 1));
            deq_ready = (i < 800) ? ($urandom_range(9) < 8) : ($urandom_range(9) < 3);
            flush = ($urandom_range(199) == 0);
            clr_err = ($urandom_range(49) == 0);
            cyc();
        end
        idle();
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
